// File: rtl/xaddr_router_pkg.sv
// Shared types and constants for the address router and its match unit.
// Holds the state encoding, the default 4-slave map and the trap read value.
package xaddr_router_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int MAP_ADDR_W = 13;
    localparam int MAP_N_SLV  = 4;

    localparam logic [12:0] MEM_BASE  = 13'h0000;
    localparam logic [12:0] REGF_BASE = 13'h1000;
    localparam logic [12:0] LED_BASE  = 13'h1010;
    localparam logic [12:0] EXT_BASE  = 13'h1800;

    localparam logic [4:0] MEM_AW  = 5'd12;
    localparam logic [4:0] REGF_AW = 5'd4;
    localparam logic [4:0] LED_AW  = 5'd0;
    localparam logic [4:0] EXT_AW  = 5'd8;

    localparam logic [51:0] MAP_SLV_BASE = {EXT_BASE, LED_BASE, REGF_BASE, MEM_BASE};
    localparam logic [19:0] MAP_SLV_AW   = {EXT_AW, LED_AW, REGF_AW, MEM_AW};

    // Every bit of the value returned on a trapped read.
    localparam logic TRAP_RD_BIT = 1'b0;

    // Mask of the low 'aw' offset bits of an address.
    function automatic logic [31:0] low_mask(input logic [4:0] aw);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int b = 0; b < 32; b++) begin
            m[b] = (b < int'(aw));
        end
        return m;
    endfunction

endpackage

// File: rtl/xaddr_match.sv
// Combinational N-way base/mask address compare with lowest-index priority.
// Shared by the data-port router and the debug-port decoder.
module xaddr_match
    import xaddr_router_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int N_SLV  = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {(N_SLV*ADDR_W){1'b0}},
    parameter logic [N_SLV*5-1:0]      SLV_AW   = {(N_SLV*5){1'b0}},
    parameter int IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_SLV-1:0]  hit,
    output logic [IDX_W-1:0]  idx,
    output logic              miss
);

    for (genvar i = 0; i < N_SLV; i++) begin : g_cmp
        localparam logic [31:0]       LOW  = low_mask(SLV_AW[i*5 +: 5]);
        localparam logic [ADDR_W-1:0] BASE = SLV_BASE[i*ADDR_W +: ADDR_W];
        assign hit[i] = ((addr & ~LOW[ADDR_W-1:0]) == BASE);
    end

    // Priority encoder: scanning downward leaves the lowest hit index.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = N_SLV - 1; i >= 0; i--) begin
            idx = hit[i] ? IDX_W'(i) : idx;
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/xaddr_router.sv
// Routes one master access to one of N_SLV slaves with wait-states,
// a stall watchdog, unmapped-address trap and saturating trap counter.
module xaddr_router
    import xaddr_router_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int N_SLV   = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {(N_SLV*ADDR_W){1'b0}},
    parameter logic [N_SLV*5-1:0]      SLV_AW   = {(N_SLV*5){1'b0}},
    parameter int TIMEOUT = 16,
    parameter int ERR_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    sel,
    input  logic                    we,
    output logic                    ready,
    output logic [N_SLV-1:0]        slv_sel,
    input  logic [N_SLV-1:0]        slv_ready,
    input  logic [N_SLV*DATA_W-1:0] slv_data_to_rd,
    output logic                    slv_we,
    output logic [DATA_W-1:0]       data_to_rd,
    output logic                    rd_valid,
    output logic                    trap_sel,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state_r, state_nx_s;
    logic [IDX_W-1:0] idx_r, idx_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;

    logic [N_SLV-1:0] m_hit_s;
    logic [IDX_W-1:0] m_idx_s;
    logic             m_miss_s;
    logic [IDX_W-1:0] cur_idx_s;
    logic             cur_ready_s;
    logic             timeout_s;

    xaddr_match #(
        .ADDR_W   (ADDR_W),
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_AW   (SLV_AW),
        .IDX_W    (IDX_W)
    ) u_match (
        .addr (addr),
        .hit  (m_hit_s),
        .idx  (m_idx_s),
        .miss (m_miss_s)
    );

    // In WAIT the latched index is used; addr is not re-decoded.
    assign cur_idx_s   = (state_r == ST_WAIT) ? idx_r : m_idx_s;
    assign cur_ready_s = slv_ready[cur_idx_s];
    assign timeout_s   = (TIMEOUT != 0) && (cnt_r == CNT_W'(TIMEOUT));
    assign slv_we      = we;

    // State, latched slave index and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (sel && !m_miss_s && !cur_ready_s) begin
                    state_nx_s = ST_WAIT;
                    idx_nx_s   = m_idx_s;
                    cnt_nx_s   = CNT_W'(1'b1);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!sel || cur_ready_s || timeout_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Combinational handshake outputs; slv_ready wins over the watchdog.
    always_comb begin
        ready    = 1'b0;
        trap_sel = 1'b0;
        slv_sel  = {N_SLV{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (sel) begin
                    if (m_miss_s) begin
                        trap_sel = 1'b1;
                        ready    = 1'b1;
                    end else begin
                        slv_sel[m_idx_s] = 1'b1;
                        ready            = cur_ready_s;
                    end
                end else begin
                    ready = 1'b0;
                end
            end
            ST_WAIT: begin
                if (sel) begin
                    slv_sel[idx_r] = 1'b1;
                    if (cur_ready_s) begin
                        ready = 1'b1;
                    end else if (timeout_s) begin
                        ready    = 1'b1;
                        trap_sel = 1'b1;
                    end else begin
                        ready = 1'b0;
                    end
                end else begin
                    ready = 1'b0;
                end
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Read-data return and saturating trap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_to_rd <= {DATA_W{1'b0}};
            rd_valid   <= 1'b0;
            err_cnt    <= {ERR_W{1'b0}};
        end else begin
            rd_valid <= ready & ~we;
            if (ready && !we) begin
                data_to_rd <= trap_sel ? {DATA_W{TRAP_RD_BIT}}
                                       : slv_data_to_rd[int'(cur_idx_s)*DATA_W +: DATA_W];
            end else begin
                data_to_rd <= data_to_rd;
            end
            if (trap_sel && !(&err_cnt)) begin
                err_cnt <= err_cnt + ERR_W'(1'b1);
            end else begin
                err_cnt <= err_cnt;
            end
        end
    end

endmodule

// File: tb/tb_xaddr_router.sv
// Directed bench for xaddr_router: zero-wait, wait-state, trap, timeout,
// reset, abort, overlap priority and counter saturation.
module tb_xaddr_router;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int N_SLV  = 4;
    localparam int ERR_W  = 8;
    localparam logic [51:0] BASE_MAP = {13'h1800, 13'h1010, 13'h1000, 13'h0000};
    localparam logic [51:0] BASE_OVL = {13'h1800, 13'h1005, 13'h1000, 13'h0000};
    localparam logic [19:0] AW_MAP   = {5'd8, 5'd0, 5'd4, 5'd12};

    logic                    clk, rst, sel, we;
    logic [ADDR_W-1:0]       addr;
    logic [N_SLV-1:0]        slv_ready;
    logic [N_SLV*DATA_W-1:0] slv_data;

    logic              ready, slv_we, rd_valid, trap_sel;
    logic [N_SLV-1:0]  slv_sel;
    logic [DATA_W-1:0] data_to_rd;
    logic [ERR_W-1:0]  err_cnt;

    logic              o_ready, o_slv_we, o_rd_valid, o_trap_sel;
    logic [N_SLV-1:0]  o_slv_sel;
    logic [DATA_W-1:0] o_data_to_rd;
    logic [ERR_W-1:0]  o_err_cnt;

    int total = 0;
    int bad   = 0;

    xaddr_router #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV),
        .SLV_BASE(BASE_MAP), .SLV_AW(AW_MAP), .TIMEOUT(16), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .sel(sel), .we(we),
        .ready(ready), .slv_sel(slv_sel), .slv_ready(slv_ready),
        .slv_data_to_rd(slv_data), .slv_we(slv_we), .data_to_rd(data_to_rd),
        .rd_valid(rd_valid), .trap_sel(trap_sel), .err_cnt(err_cnt)
    );

    // Second instance whose slave 2 sits inside slave 1's window.
    xaddr_router #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV),
        .SLV_BASE(BASE_OVL), .SLV_AW(AW_MAP), .TIMEOUT(16), .ERR_W(ERR_W)
    ) dut_ovl (
        .clk(clk), .rst(rst), .addr(addr), .sel(sel), .we(we),
        .ready(o_ready), .slv_sel(o_slv_sel), .slv_ready(slv_ready),
        .slv_data_to_rd(slv_data), .slv_we(o_slv_we), .data_to_rd(o_data_to_rd),
        .rd_valid(o_rd_valid), .trap_sel(o_trap_sel), .err_cnt(o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        we        = 1'b0;
        addr      = 13'h0000;
        slv_ready = 4'b0000;
        slv_data  = {32'h3333_4444, 32'h5555_AAAA, 32'h1111_2222, 32'hA5A5_A5A5};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_err", 32'(err_cnt), 32'h0);
        chk("rst_rdv", 32'(rd_valid), 32'h0);
        chk("rst_data", data_to_rd, 32'h0);
        chk("rst_sel", 32'(slv_sel), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait read from slave 0
        addr = 13'h0123; sel = 1'b1; slv_ready = 4'b0001;
        #1;
        chk("zw_ready", 32'(ready), 32'h1);
        chk("zw_sel", 32'(slv_sel), 32'h1);
        chk("zw_trap", 32'(trap_sel), 32'h0);
        @(posedge clk); #1;
        chk("zw_rdv", 32'(rd_valid), 32'h1);
        chk("zw_data", data_to_rd, 32'hA5A5_A5A5);
        sel = 1'b0; slv_ready = 4'b0000;
        @(posedge clk); #1;
        chk("zw_rdv_drop", 32'(rd_valid), 32'h0);

        // Unmapped read
        addr = 13'h1F00; sel = 1'b1;
        #1;
        chk("miss_trap", 32'(trap_sel), 32'h1);
        chk("miss_ready", 32'(ready), 32'h1);
        chk("miss_sel", 32'(slv_sel), 32'h0);
        @(posedge clk); #1;
        chk("miss_err", 32'(err_cnt), 32'h1);
        chk("miss_rdv", 32'(rd_valid), 32'h1);
        chk("miss_data", data_to_rd, 32'h0);
        sel = 1'b0;
        @(posedge clk); #1;

        // Three wait-states on slave 1; other ready bits must be ignored
        addr = 13'h1005; sel = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            slv_ready = (c == 4) ? 4'b0010 : 4'b1101;
            #1;
            chk($sformatf("ws_sel_%0d", c), 32'(slv_sel), 32'h2);
            chk($sformatf("ws_ready_%0d", c), 32'(ready), (c == 4) ? 32'h1 : 32'h0);
            chk($sformatf("ws_trap_%0d", c), 32'(trap_sel), 32'h0);
            if (c == 1) chk("ovl_sel", 32'(o_slv_sel), 32'h2);
            @(posedge clk); #1;
        end
        chk("ws_rdv", 32'(rd_valid), 32'h1);
        chk("ws_data", data_to_rd, 32'h1111_2222);
        chk("ws_err", 32'(err_cnt), 32'h1);

        // Zero-wait write to slave 2: no rd_valid, data holds
        addr = 13'h1010; we = 1'b1; slv_ready = 4'b0100;
        #1;
        chk("wr_ready", 32'(ready), 32'h1);
        chk("wr_we", 32'(slv_we), 32'h1);
        chk("wr_sel", 32'(slv_sel), 32'h4);
        @(posedge clk); #1;
        chk("wr_rdv", 32'(rd_valid), 32'h0);
        chk("wr_data", data_to_rd, 32'h1111_2222);
        sel = 1'b0; we = 1'b0; slv_ready = 4'b0000;
        @(posedge clk); #1;

        // Slave 3 never ready: watchdog fires on the 17th cycle
        addr = 13'h1850; sel = 1'b1; slv_ready = 4'b0111;
        for (int c = 1; c <= 17; c++) begin
            #1;
            chk($sformatf("to_sel_%0d", c), 32'(slv_sel), 32'h8);
            chk($sformatf("to_ready_%0d", c), 32'(ready), (c == 17) ? 32'h1 : 32'h0);
            chk($sformatf("to_trap_%0d", c), 32'(trap_sel), (c == 17) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        chk("to_rdv", 32'(rd_valid), 32'h1);
        chk("to_data", data_to_rd, 32'h0);
        chk("to_err", 32'(err_cnt), 32'h2);
        sel = 1'b0; slv_ready = 4'b0000;
        @(posedge clk); #1;

        // Reset during WAIT cycle 2; comb outputs follow IDLE decode
        addr = 13'h1005; sel = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; addr = 13'h0123; slv_ready = 4'b0001;
        #1;
        chk("rstw_err", 32'(err_cnt), 32'h0);
        chk("rstw_rdv", 32'(rd_valid), 32'h0);
        chk("rstw_data", data_to_rd, 32'h0);
        chk("rstw_sel", 32'(slv_sel), 32'h1);
        chk("rstw_ready", 32'(ready), 32'h1);
        sel = 1'b0; slv_ready = 4'b0000;
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstw_rdv2", 32'(rd_valid), 32'h0);

        // Abort: sel dropped in WAIT
        addr = 13'h1005; sel = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0;
        #1;
        chk("ab_sel", 32'(slv_sel), 32'h0);
        chk("ab_ready", 32'(ready), 32'h0);
        chk("ab_trap", 32'(trap_sel), 32'h0);
        @(posedge clk); #1;
        chk("ab_rdv", 32'(rd_valid), 32'h0);
        chk("ab_err", 32'(err_cnt), 32'h0);
        addr = 13'h0123; sel = 1'b1; slv_ready = 4'b0001;
        #1;
        chk("ab_idle_sel", 32'(slv_sel), 32'h1);
        chk("ab_idle_ready", 32'(ready), 32'h1);
        @(posedge clk); #1;
        sel = 1'b0; slv_ready = 4'b0000;
        @(posedge clk); #1;

        // 260 back-to-back unmapped accesses saturate the counter
        addr = 13'h1F00; sel = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            @(posedge clk); #1;
            if (i == 254) chk("sat_254", 32'(err_cnt), 32'd254);
            if (i == 255) chk("sat_255", 32'(err_cnt), 32'd255);
        end
        chk("sat_end", 32'(err_cnt), 32'd255);
        sel = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xaddr_router.md
Name: xaddr_router

Overview:
- Parametrised successor of the fixed-map address decoder.
- Routes one master access (addr/sel/we) to one of N_SLV slaves, each with its own base and offset width.
- Supports slave wait-states through per-slave ready, with a timeout watchdog that raises trap on a stalled slave.
- Provides a trap on unmapped addresses, a registered read-data return, and a saturating error counter.
- Sits between the CPU data port and the memory, register file, LED, ext and debug slaves.

Parameters:
- ADDR_W, 13: master address width.
- DATA_W, 32: data width.
- N_SLV, 4: number of slave channels, 1..8.
- SLV_BASE, 0: packed N_SLV*ADDR_W; base address of slave i in slice i.
- SLV_AW, 0: packed N_SLV*5; offset width of slave i, 0..ADDR_W.
- TIMEOUT, 16: maximum wait cycles before trap. 0 disables the watchdog.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  ADDR_W  master address; the master holds it stable while sel=1.
- sel  in  1  master access request.
- we  in  1  write enable; passed through to slaves unchanged.
- ready  out  1  access complete this cycle (comb).
- slv_sel  out  N_SLV  one-hot slave select (comb).
- slv_ready  in  N_SLV  slave done, sampled only on the selected bit.
- slv_data_to_rd  in  N_SLV*DATA_W  packed slave read data.
- slv_we  out  1  equals we.
- data_to_rd  out  DATA_W  registered read data.
- rd_valid  out  1  registered; data_to_rd is valid for this one cycle.
- trap_sel  out  1  one-cycle pulse on an unmapped or timed-out access (comb).
- err_cnt  out  ERR_W  saturating count of traps (registered).

Behaviour:
- Decode (comb):
  - hit_i = (addr & ~((1<<SLV_AW_i)-1)) == SLV_BASE_i.
  - The lowest hit index wins on overlap.
  - miss = no hit_i set.
- State machine, 2 states: IDLE and WAIT. Registers: state, idx_q (clog2 N_SLV bits), cnt (clog2(TIMEOUT+1) bits).
- IDLE with sel=0: all outputs idle.
- IDLE with sel=1 and miss:
  - trap_sel=1 and ready=1 in the same cycle.
  - err_cnt+1, saturating; stay in IDLE; no slv_sel bit set.
- IDLE with sel=1 and a hit on index k:
  - slv_sel[k]=1 in the same cycle.
  - If slv_ready[k]=1: ready=1; capture slv_data_to_rd[k] into data_to_rd; set rd_valid=1 next cycle; stay in IDLE. This is a zero-wait access.
  - Otherwise: idx_q<=k, cnt<=1, go to WAIT.
- WAIT with sel=1:
  - slv_sel[idx_q]=1; addr is not re-decoded.
  - If slv_ready[idx_q]=1: ready=1, capture data, go to IDLE.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT: trap_sel=1, ready=1, data_to_rd<=0, rd_valid<=1, err_cnt+1, go to IDLE.
  - Else: cnt+1.
- WAIT with sel=0: abort. slv_sel drops in the same cycle; go to IDLE; no ready, trap or count.
- rd_valid:
  - Asserted for exactly one cycle after each ready with we=0.
  - Never asserted for writes; data_to_rd holds its last value.
- Simultaneous slv_ready and the timeout condition: slv_ready wins (no trap).
- err_cnt saturates at all-ones and never wraps.
- Reset, asynchronous and allowed mid-WAIT: state=IDLE, idx_q=0, cnt=0, data_to_rd=0, rd_valid=0, err_cnt=0. Comb outputs follow from IDLE with the current inputs.
- Only the selected channel's slv_ready affects behaviour; other bits are ignored.

Decomposition:
- Shared package/header holds:
  - the state encoding (ST_IDLE=0, ST_WAIT=1);
  - the default slave map constants for the 4-slave system (MEM, REGF, LED, EXT bases and widths);
  - the trap read value (0).
- One sub-module: xaddr_match, a combinational N-way base/mask compare plus priority encoder. It outputs hit, idx and miss, and is reused by the debug port decoder.

Test Plan:
- Map {0x000/12, 0x1000/4, 0x1010/0, 0x1800/8}, addr=0x0123, sel=1, slv_ready[0]=1, data 0xA5A5A5A5 -> same cycle ready=1 and slv_sel=0001; next cycle rd_valid=1 and data_to_rd=0xA5A5A5A5.
- addr=0x1F00 (unmapped), sel=1 -> trap_sel=1 and ready=1 in one cycle, err_cnt 0->1, slv_sel=0.
- addr=0x1005, slv_ready[1] rises after 3 cycles -> slv_sel=0010 held 4 cycles, ready on the 4th, no trap.
- TIMEOUT=16, slave 3 never ready -> ready and trap_sel on the 17th cycle of sel, then rd_valid with data_to_rd=0, err_cnt+1.
- Assert rst in WAIT cycle 2 -> state IDLE immediately, err_cnt=0, rd_valid=0; sel dropped in WAIT -> no ready or trap.
- 260 unmapped accesses with ERR_W=8 -> err_cnt saturates at 255; overlap address hitting slaves 1 and 2 -> slave 1 selected.
